// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-bit shift controller stepping a 1-bit shifter.
// Optional carry-out port enabled by defining SHIFT_CARRY_EN.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_CARRY_EN
  output logic             cout,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] count_q;
  logic [AMT_W-1:0] count_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
`ifdef SHIFT_CARRY_EN
  logic             shout_d;
  logic             carry_q;
  logic             cout_q;
`endif

  // One single-bit step of the captured operand
  always_comb begin
    data_d  = data_q;
    count_d = count_q - AMT_W'(1);
`ifdef SHIFT_CARRY_EN
    shout_d = 1'b0;
`endif
    case (op_q)
      2'b01: begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_CARRY_EN
        shout_d = data_q[WIDTH-1];
`endif
      end
      2'b10: begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
`ifdef SHIFT_CARRY_EN
        shout_d = data_q[0];
`endif
      end
      2'b11: begin
        data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFT_CARRY_EN
        shout_d = data_q[0];
`endif
      end
      default: data_d = data_q;
    endcase
  end

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      op_q     <= 2'b00;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef SHIFT_CARRY_EN
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            data_q  <= in;
            op_q    <= op;
            count_q <= amt;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
`ifdef SHIFT_CARRY_EN
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (count_q == '0 || op_q == 2'b00)
            state_q <= S_DONE;
          else
            state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          data_q  <= data_d;
          count_q <= count_d;
`ifdef SHIFT_CARRY_EN
          carry_q <= shout_d;
`endif
          if (count_q == AMT_W'(1))
            state_q <= S_DONE;
        end
        S_DONE: begin
          done_q   <= 1'b1;
          result_q <= data_q;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
`ifdef SHIFT_CARRY_EN
          cout_q   <= carry_q;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef SHIFT_CARRY_EN
  assign cout   = cout_q;
`endif

endmodule
